execute_stage: RTL

//  EX stage of the 64-bit LEGv8 pipeline, directly upstream of the memory-access stage.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/seq_multiplier.sv | 67 ++++++
 rtl/execute_stage.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the LEGv8 pipeline.
// ALU op codes, EX FSM states and the EX control/context bundles.
package cpu_pkg;

    localparam int XLEN = 64;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_LSL   = 4'b1001;
    localparam logic [3:0] ALU_LSR   = 4'b1010;
    localparam logic [3:0] ALU_MUL   = 4'b1000;

    typedef enum logic {
        IDLE,
        MUL_RUN
    } ex_state_t;

    typedef struct packed {
        logic branch;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
    } ctrl_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] baddr;
        logic [XLEN-1:0] data2;
        ctrl_t           ctrl;
    } mul_ctx_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// The final step is presented combinationally and held while hold is high.
module seq_multiplier
    import cpu_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic         hold,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  acc;
    logic [W-1:0]  mcand;
    logic [W-1:0]  mplier;
    logic [CW-1:0] cnt;
    logic [W-1:0]  addend;
    logic [W-1:0]  acc_nxt;

    assign addend  = mplier[0] ? mcand : '0;
    assign acc_nxt = acc + addend;
    assign done    = busy && (cnt == CW'(W - 1));
    assign product = acc_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (abort) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            if (done) begin
                // last step waits here until the consumer can take it
                if (!hold) begin
                    acc  <= acc_nxt;
                    busy <= 1'b0;
                    cnt  <= '0;
                end
            end else begin
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/execute_stage.sv
// LEGv8 EX stage: ALU, branch target adder, iterative MUL, EX/MEM register.
// MUL holds decode off via ex_ready; flush squashes EX and its output.
module execute_stage
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    output logic            ex_ready,
    input  logic [31:0]     id_instr,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rdata1,
    input  logic [XLEN-1:0] id_rdata2,
    input  logic [XLEN-1:0] id_imm,
    input  logic [3:0]      id_alu_op,
    input  logic            id_alu_src,
    input  logic            id_branch,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_mem_to_reg,
    input  logic            id_reg_write,
    input  logic            stall,
    input  logic            flush,
    output logic            mem_valid,
    output logic [31:0]     mem_instr,
    output logic [XLEN-1:0] mem_branch_addr,
    output logic [XLEN-1:0] mem_result,
    output logic [XLEN-1:0] mem_data2,
    output logic            mem_zero,
    output logic            mem_branch,
    output logic            mem_mem_read,
    output logic            mem_mem_write,
    output logic            mem_mem_to_reg,
    output logic            mem_reg_write
);

    localparam int SHW = $clog2(XLEN);

    ex_state_t       state_q;
    ex_state_t       state_d;
    mul_ctx_t        ctx_q;
    ctrl_t           ctrl_in;
    ctrl_t           ctrl_q;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] baddr;
    logic [XLEN-1:0] mul_product;
    logic            mul_busy;
    logic            mul_done;
    logic            is_mul;
    logic            accept;
    logic            mul_start;
    logic            load_alu;
    logic            load_mul;
    logic            load_bubble;

    assign ctrl_in = '{branch:     id_branch,
                       mem_read:   id_mem_read,
                       mem_write:  id_mem_write,
                       mem_to_reg: id_mem_to_reg,
                       reg_write:  id_reg_write};

    assign op_b      = id_alu_src ? id_imm : id_rdata2;
    assign baddr     = id_pc + (id_imm << 2);
    assign is_mul    = (id_alu_op == ALU_MUL);
    assign ex_ready  = (state_q == IDLE) && !stall && !flush;
    assign accept    = id_valid && ex_ready;
    assign mul_start = accept && is_mul;

    always_comb begin
        alu_res = '0;
        case (id_alu_op)
            ALU_AND:   alu_res = id_rdata1 & op_b;
            ALU_ORR:   alu_res = id_rdata1 | op_b;
            ALU_ADD:   alu_res = id_rdata1 + op_b;
            ALU_SUB:   alu_res = id_rdata1 - op_b;
            ALU_PASSB: alu_res = op_b;
            ALU_NOR:   alu_res = ~(id_rdata1 | op_b);
            ALU_LSL:   alu_res = id_rdata1 << op_b[SHW-1:0];
            ALU_LSR:   alu_res = id_rdata1 >> op_b[SHW-1:0];
            default:   alu_res = '0;
        endcase
    end

    seq_multiplier #(.W(XLEN)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .abort   (flush),
        .hold    (stall),
        .a       (id_rdata1),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_d     = state_q;
        load_alu    = 1'b0;
        load_mul    = 1'b0;
        load_bubble = 1'b0;
        if (flush) begin
            load_bubble = 1'b1;
            state_d     = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!stall) begin
                        if (accept && !is_mul)
                            load_alu = 1'b1;
                        else
                            load_bubble = 1'b1;
                        if (mul_start)
                            state_d = MUL_RUN;
                    end
                end
                MUL_RUN: begin
                    if (!stall) begin
                        if (mul_done && mul_busy) begin
                            load_mul = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            load_bubble = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ctx_q <= '0;
        else if (mul_start)
            ctx_q <= '{instr: id_instr, baddr: baddr,
                       data2: id_rdata2, ctrl: ctrl_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid       <= 1'b0;
            mem_instr       <= '0;
            mem_branch_addr <= '0;
            mem_result      <= '0;
            mem_data2       <= '0;
            mem_zero        <= 1'b0;
            ctrl_q          <= '0;
        end else if (load_alu) begin
            mem_valid       <= 1'b1;
            mem_instr       <= id_instr;
            mem_branch_addr <= baddr;
            mem_result      <= alu_res;
            mem_data2       <= id_rdata2;
            mem_zero        <= (alu_res == '0);
            ctrl_q          <= ctrl_in;
        end else if (load_mul) begin
            mem_valid       <= 1'b1;
            mem_instr       <= ctx_q.instr;
            mem_branch_addr <= ctx_q.baddr;
            mem_result      <= mul_product;
            mem_data2       <= ctx_q.data2;
            mem_zero        <= (mul_product == '0);
            ctrl_q          <= ctx_q.ctrl;
        end else if (load_bubble) begin
            mem_valid <= 1'b0;
            ctrl_q    <= '0;
        end
    end

    assign mem_branch     = ctrl_q.branch;
    assign mem_mem_read   = ctrl_q.mem_read;
    assign mem_mem_write  = ctrl_q.mem_write;
    assign mem_mem_to_reg = ctrl_q.mem_to_reg;
    assign mem_reg_write  = ctrl_q.reg_write;

endmodule
